// File: rtl/sram_like_pkg.sv
// rtl/sram_like_pkg.sv - shared sram-like bus encodings, FSM states and lane helpers
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    DATA_WAIT,
    RESP
  } state_e;

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SIZE_BYTE: return 4'b0001 << lo;
      SIZE_HALF: return 4'b0011 << lo;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic misalign(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == SIZE_HALF && lo[0]) || (sz == SIZE_WORD && lo != 2'd0) || (sz == 2'd3);
  endfunction

endpackage

// File: rtl/sram_like_mem_array.sv
// rtl/sram_like_mem_array.sv - word memory with byte-lane write and synchronous read
module sram_like_mem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  // Contents are deliberately never reset; o_rdata holds between reads.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) o_rdata <= r_mem[i_idx];
  end

endmodule

// File: rtl/sram_like_mem_slave.sv
// rtl/sram_like_mem_slave.sv - sram-like responder with configurable address/data latency
module sram_like_mem_slave
  import sram_like_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_LAT   = 1,
  parameter int DATA_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam logic [7:0] LAT_TGT     = 8'(ADDR_LAT);
  localparam logic [7:0] DCNT_INIT   = 8'(DATA_LAT - 1);
  localparam bit         DIRECT_RESP = (DATA_LAT <= 1);

  state_e                r_state;
  logic [7:0]            r_lat_cnt;
  logic [7:0]            r_dcnt;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic [DEPTH_LOG2+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_data_ok;
  logic                  r_err;
  logic                  r_rdata_zero;

  logic                  w_in_idle;
  logic                  w_hs;
  logic                  w_go_resp;
  logic                  w_wr;
  logic [1:0]            w_size;
  logic [DEPTH_LOG2+1:0] w_addr;
  logic [31:0]           w_wdata;
  logic                  w_bad;
  logic                  w_mem_we;
  logic                  w_mem_re;
  logic [31:0]           w_q;
  logic                  w_unused;

  assign w_unused  = ^addr[31:DEPTH_LOG2+2];
  assign w_in_idle = (r_state == IDLE);
  assign addr_ok   = rst_n & w_in_idle & req & (r_lat_cnt == LAT_TGT);
  assign w_hs      = addr_ok;

  // With DATA_LAT=1 the handshake edge is also the RESP-entry edge, so the
  // transfer fields come straight from the bus instead of the capture regs.
  assign w_go_resp = (w_hs & DIRECT_RESP) | ((r_state == DATA_WAIT) & (r_dcnt <= 8'd1));
  assign w_wr      = w_in_idle ? wr : r_wr;
  assign w_size    = w_in_idle ? size : r_size;
  assign w_addr    = w_in_idle ? addr[DEPTH_LOG2+1:0] : r_addr;
  assign w_wdata   = w_in_idle ? wdata : r_wdata;
  assign w_bad     = misalign(w_size, w_addr[1:0]);
  assign w_mem_we  = w_go_resp & w_wr & ~w_bad;
  assign w_mem_re  = w_go_resp & ~w_wr & ~w_bad;

  assign data_ok = r_data_ok;
  assign err     = r_err;
  assign rdata   = r_rdata_zero ? 32'h0 : w_q;

  sram_like_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_be    (be_of(w_size, w_addr[1:0])),
    .i_re    (w_mem_re),
    .i_idx   (w_addr[DEPTH_LOG2+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lat_cnt    <= 8'd0;
      r_dcnt       <= 8'd0;
      r_wr         <= 1'b0;
      r_size       <= SIZE_BYTE;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_data_ok    <= 1'b0;
      r_err        <= 1'b0;
      r_rdata_zero <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_wr      <= wr;
            r_size    <= size;
            r_addr    <= addr[DEPTH_LOG2+1:0];
            r_wdata   <= wdata;
            r_lat_cnt <= 8'd0;
            r_dcnt    <= DCNT_INIT;
            r_state   <= DATA_WAIT;
          end else if (req) begin
            r_lat_cnt <= r_lat_cnt + 8'd1;
          end else begin
            r_lat_cnt <= 8'd0;
          end
        end
        DATA_WAIT: r_dcnt <= r_dcnt - 8'd1;
        RESP: begin
          r_data_ok <= 1'b0;
          r_err     <= 1'b0;
          r_lat_cnt <= 8'd0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Entering RESP overrides whatever the state arm chose above.
      if (w_go_resp) begin
        r_state      <= RESP;
        r_data_ok    <= 1'b1;
        r_err        <= w_bad;
        r_rdata_zero <= w_wr | w_bad;
      end
    end
  end

endmodule

// File: doc/sram_like_mem_slave.md
Name: sram_like_mem_slave

Overview:
Responder end of the sram-like bus. It accepts one sram-like request at a time (req/addr_ok handshake) and returns data_ok/rdata after a configurable latency. It is backed by a word-organised on-chip memory with byte-lane writes. It serves as the memory-side endpoint for the instruction and data sram-like initiators, both in simulation benches and in small standalone configurations.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words; index = addr[DEPTH_LOG2+1:2]; upper address bits ignored (aliased)
ADDR_LAT, 1, cycles req must be held in IDLE before addr_ok; 0 = combinational addr_ok in the first cycle
DATA_LAT, 2, cycles from the addr handshake edge to the data_ok cycle; legal range >=1

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  request valid from the initiator
wr  in  1  1 = write, 0 = read
size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as an error
addr  in  32  byte address
wdata  in  32  write data, lane-aligned (byte at addr[1:0] sits in lane addr[1:0])
addr_ok  out  1  address handshake; a transfer is accepted on the edge where req & addr_ok
data_ok  out  1  one-cycle pulse marking completion
rdata  out  32  full read word, valid in the data_ok cycle and held until the next data_ok
err  out  1  pulses together with data_ok for a misaligned or illegal-size transfer

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counters=0, addr_ok=0 (gated by rst_n even when ADDR_LAT=0), data_ok=0, rdata=0, err=0. Memory contents are not reset.
- FSM states:
  - IDLE: lat_cnt counts consecutive cycles with req=1. addr_ok=1 when req & lat_cnt==ADDR_LAT. If req falls early, lat_cnt clears and the state stays IDLE. On the handshake edge: capture wr/size/addr/wdata, go to DATA_WAIT, load dcnt=DATA_LAT-1.
  - DATA_WAIT: addr_ok=0 regardless of req. dcnt decrements each cycle; at dcnt==0 go to RESP.
  - RESP: data_ok=1 for exactly one cycle. Next state is IDLE with lat_cnt=0.
- Only one transfer is outstanding. addr_ok and data_ok are never high in the same cycle.
- Earliest back-to-back sequence: data_ok in cycle N, next addr_ok in cycle N+1+ADDR_LAT (the ADDR_LAT=0 case gives N+1).
- Latency from the handshake edge to data_ok is exactly DATA_LAT cycles.
- Alignment check: error if size==1 and addr[0]=1, or size==2 and addr[1:0]!=0, or size==3.
  - On error: no memory write, rdata=0, err=1 in the RESP cycle.
- Write: byte enables derive from size and addr[1:0] (byte: 1<<addr[1:0]; half: 3<<addr[1:0]; word: 4'hF).
  - Only the enabled lanes of wdata update the word.
  - Committed on the RESP-entry edge; in the data_ok cycle rdata=0.
- Read: returns the full 32-bit word at the index regardless of size; the initiator extracts lanes. The array is read synchronously, timed so rdata is valid in the RESP cycle.
- Read-after-write to the same address returns the new data, guaranteed by single-outstanding plus write at RESP entry.
- Reset mid-transfer (IDLE counting, DATA_WAIT or RESP): the transfer is dropped, no data_ok is issued, and a pending write is not performed.

Decomposition:
- Package sram_like_pkg: size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD, FSM state enum (IDLE, DATA_WAIT, RESP), a byte-enable function be_of(size, addr_lo), and a misalign function. The pkg is shared with the initiator bridges.
- One sub-module, sram_like_mem_array: DEPTH words x 32, 4-bit byte-enable write port, synchronous read port.

Test Plan:
1. rst_n=0 with req=1 and addr=0 -> addr_ok=0, data_ok=0, rdata=0, err=0 throughout; after release, the first addr_ok follows 1 cycle of held req (ADDR_LAT=1).
2. Word write addr=0x10, wdata=0xDEADBEEF, then word read 0x10 -> write data_ok exactly 2 cycles after its handshake; read returns rdata=0xDEADBEEF, err=0.
3. Word 0x20=0x11223344; byte write addr=0x23, wdata=0xAA000000 -> read 0x20 returns 0xAA223344. Then half write addr=0x20, wdata=0x0000BEEF -> read returns 0xAA22BEEF.
4. Half write addr=0x21 and word read addr=0x22 -> each gives data_ok with err=1; the read gives rdata=0; word 0x20 is unchanged.
5. req held high continuously across two reads -> the second addr_ok appears exactly ADDR_LAT+1 cycles after the first data_ok, with no addr_ok while in DATA_WAIT. With ADDR_LAT=0: addr_ok in the same cycle as req in IDLE.
6. Word write 0x40=0x55 accepted, then rst_n pulsed low during DATA_WAIT -> no data_ok; a subsequent read of 0x40 returns the prior value. Also check aliasing: a read of 0x1040 (DEPTH_LOG2=10) returns the same word as 0x40.
